sc_n_adder_tree: RTL and testbench

Parametrised, pipelined stochastic scaled-adder tree that sums N unipolar bitstreams to one output stream of value mean(inputs). The block generates its own 0.5-probability select streams from an internal LFSR. Each run lasts a fixed stream length, controlled by start, in_valid and done. During a run the block also counts the ones in the output stream, giving a binary estimate of the sum. It sits between stochastic number generators and the binary back-end, and replaces serial adder chains where N is large.

---
 rtl/sc_n_adder_tree_if.sv | 29 ++
 rtl/sc_n_adder_tree.sv | 138 +++++++++++++
 tb/tb_sc_n_adder_tree.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sc_n_adder_tree_if.sv
`default_nettype none
// ============================================================================
// sc_n_adder_tree_if : run control and stream bus of the stochastic adder tree.
// Revision 1.0
// ============================================================================
interface sc_n_adder_tree_if #(
   parameter int N     = 8,
   parameter int LEN_W = 8
);
   logic           start;
   logic           in_valid;
   logic [N-1:0]   inputs;
   logic           sum;
   logic           sum_valid;
   logic [LEN_W:0] count;
   logic           busy;
   logic           done;

   modport master (
      output start, in_valid, inputs,
      input  sum, sum_valid, count, busy, done
   );

   modport slave (
      input  start, in_valid, inputs,
      output sum, sum_valid, count, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/sc_n_adder_tree.sv
`default_nettype none
// ============================================================================
// sc_n_adder_tree : pipelined stochastic scaled-adder tree, N streams -> mean.
// Revision 1.0
// ============================================================================
module sc_n_adder_tree #(
   parameter int          N     = 8,
   parameter int          LEN_W = 8,
   parameter logic [15:0] SEED  = 16'hACE1
) (
   input  wire logic        clk,
   input  wire logic        rst,
   sc_n_adder_tree_if.slave bus
);
   localparam int D = $clog2(N);
   localparam logic [LEN_W:0] c_STREAM_LEN = {1'b1, {LEN_W{1'b0}}};

   if (N < 2 || N > 65536 || (N & (N - 1)) != 0) begin : g_bad_n
      $error("sc_n_adder_tree: N must be a power of two in 2..65536");
   end
   if (LEN_W < 1 || LEN_W > 24) begin : g_bad_len
      $error("sc_n_adder_tree: LEN_W must be in 1..24");
   end
   if (SEED == 16'h0000) begin : g_bad_seed
      $error("sc_n_adder_tree: SEED must be nonzero");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   logic [15:0]      r_lfsr;
   logic [LEN_W-1:0] r_scnt;
   logic [LEN_W:0]   r_count;
   logic [D-1:0]     r_v;
   logic             r_sum_valid;
   logic             r_busy;
   logic             r_done;

   // Level k occupies bits [2N-2*(N>>k) +: N>>k]; inputs sit in [N-1:0].
   logic [2*N-2:N]   r_tree;
   logic [2*N-2:N]   w_tree_nxt;
   logic [2*N-2:0]   w_all;

   logic             w_accept;
   logic             w_adv;
   logic             w_lfsr_fb;
   logic [D-1:0]     w_v_nxt;
   logic [D-1:0]     w_v_up;

   assign w_accept  = (r_state == S_RUN) && bus.in_valid;
   assign w_adv     = w_accept || (r_state == S_DRAIN);
   assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
   assign w_all     = {r_tree, bus.inputs};

   always_comb begin
      w_v_nxt     = r_v << 1;
      w_v_nxt[0]  = w_accept;
      w_v_up      = r_v;
      w_v_up[D-1] = 1'b0;
   end

   for (genvar k = 1; k <= D; k++) begin : g_level
      localparam int W       = N >> k;
      localparam int OFF_IN  = 2 * N - 4 * W;
      localparam int OFF_OUT = 2 * N - 2 * W;
      for (genvar i = 0; i < W; i++) begin : g_node
         assign w_tree_nxt[OFF_OUT + i] = r_lfsr[k-1] ? w_all[OFF_IN + 2*i + 1]
                                                      : w_all[OFF_IN + 2*i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_tree      <= '0;
         r_v         <= '0;
         r_lfsr      <= SEED;
         r_scnt      <= '0;
         r_count     <= '0;
         r_sum_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_sum_valid <= 1'b0;
         r_done      <= 1'b0;
         if (w_adv) begin
            r_tree      <= w_tree_nxt;
            r_v         <= w_v_nxt;
            r_lfsr      <= {w_lfsr_fb, r_lfsr[15:1]};
            r_sum_valid <= w_v_nxt[D-1];
         end
         if (r_sum_valid && r_tree[2*N-2] && (r_count != c_STREAM_LEN))
            r_count <= r_count + 1'b1;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_state <= S_RUN;
                  r_busy  <= 1'b1;
                  r_count <= '0;
                  r_scnt  <= '0;
                  r_lfsr  <= SEED;
               end
            end
            S_RUN: begin
               if (w_accept) begin
                  r_scnt <= r_scnt + 1'b1;
                  if (&r_scnt)
                     r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // Last strobe is the one with nothing valid left upstream of it.
               if (r_sum_valid && (w_v_up == '0)) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.sum       = r_tree[2*N-2];
   assign bus.sum_valid = r_sum_valid;
   assign bus.count     = r_count;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sc_n_adder_tree.sv
`default_nettype none
// tb_sc_n_adder_tree: an N=4 and an N=8 instance share stimulus; each output
// stream is compared with a per-sample mux-tree reference built from the LFSR sequence.
module tb_sc_n_adder_tree;
   localparam int          LEN_W = 8;
   localparam int          L     = 1 << LEN_W;
   localparam logic [15:0] SEED  = 16'hACE1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sc_n_adder_tree_if #(.N(4), .LEN_W(LEN_W)) if4 ();
   sc_n_adder_tree_if #(.N(8), .LEN_W(LEN_W)) if8 ();

   sc_n_adder_tree #(.N(4), .LEN_W(LEN_W), .SEED(SEED)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
   sc_n_adder_tree #(.N(8), .LEN_W(LEN_W), .SEED(SEED)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

   int checks = 0;
   int errors = 0;

   logic [7:0]  stim     [L];
   logic        expv     [2][L];
   logic [15:0] lfsr_seq [L+8];

   int          cyc = 0;
   int          wp       [2];
   logic        got      [2][4096];
   int          done_n   [2];
   int          done_cyc [2];
   logic [8:0]  cnt_done [2];
   int          base_wp  [2];
   int          base_d   [2];
   int          first_cyc;

   logic [8:0]  cnt_now  [2];
   logic        busy_now [2];
   logic        sv_now   [2];
   logic        sum_now  [2];
   logic        done_now [2];

   always_comb begin
      cnt_now[0] = if4.count;  cnt_now[1] = if8.count;
      busy_now[0] = if4.busy;  busy_now[1] = if8.busy;
      sv_now[0] = if4.sum_valid; sv_now[1] = if8.sum_valid;
      sum_now[0] = if4.sum;    sum_now[1] = if8.sum;
      done_now[0] = if4.done;  done_now[1] = if8.done;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (if4.sum_valid) begin got[0][wp[0] % 4096] <= if4.sum; wp[0] <= wp[0] + 1; end
      if (if8.sum_valid) begin got[1][wp[1] % 4096] <= if8.sum; wp[1] <= wp[1] + 1; end
      if (if4.done) begin done_n[0] <= done_n[0] + 1; done_cyc[0] <= cyc; cnt_done[0] <= if4.count; end
      if (if8.done) begin done_n[1] <= done_n[1] + 1; done_cyc[1] <= cyc; cnt_done[1] <= if8.count; end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic st, input logic iv, input logic [7:0] pat);
      if4.start = st;  if8.start = st;
      if4.in_valid = iv; if8.in_valid = iv;
      if4.inputs = pat[3:0]; if8.inputs = pat;
   endtask

   // Sample j passes level k (0-based) using bit k of the LFSR state after j+k advances.
   function automatic logic tree_out(input logic [7:0] v, input int n, input int j);
      logic [7:0] cur;
      logic [7:0] nxt;
      int w;
      int k;
      cur = v; w = n; k = 0;
      while (w > 1) begin
         nxt = '0;
         for (int i = 0; i < w / 2; i++)
            nxt[i] = lfsr_seq[j+k][k] ? cur[2*i+1] : cur[2*i];
         cur = nxt; w = w / 2; k++;
      end
      return cur[0];
   endfunction

   task automatic compute_model();
      logic [15:0] s;
      s = SEED;
      for (int t = 0; t < L + 8; t++) begin
         lfsr_seq[t] = s;
         s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
      end
      for (int j = 0; j < L; j++) begin
         expv[0][j] = tree_out({4'b0000, stim[j][3:0]}, 4, j);
         expv[1][j] = tree_out(stim[j], 8, j);
      end
   endtask

   task automatic do_run(input int mode, input int gap_pct, input bit noise);
      int acc, guard;
      bit iv, prev_stall, seen4, seen8;
      for (int j = 0; j < L; j++)
         stim[j] = (mode == 0) ? 8'h00 : (mode == 1) ? 8'hFF : (mode == 2) ? 8'h01 : 8'($urandom);
      compute_model();
      for (int d = 0; d < 2; d++) begin base_wp[d] = wp[d]; base_d[d] = done_n[d]; end
      @(posedge clk); #1 drive(1'b1, 1'b1, 8'($urandom));
      @(posedge clk); #1;
      acc = 0; guard = 0; prev_stall = 1'b0; first_cyc = -1;
      while (acc < L && guard < 2000) begin
         iv = (int'($urandom_range(99)) >= gap_pct);
         drive(noise && (guard % 16 == 5), iv, iv ? stim[acc] : 8'($urandom));
         @(negedge clk);
         if (prev_stall) begin
            checks++;
            if (if4.sum_valid !== 1'b0 || if8.sum_valid !== 1'b0) begin
               errors++;
               $display("FAIL stall_strobe: sum_valid4=%b sum_valid8=%b after stalled cycle, want 0",
                        if4.sum_valid, if8.sum_valid);
            end
         end
         if (iv && first_cyc < 0) first_cyc = cyc;
         prev_stall = !iv;
         if (iv) acc++;
         guard++;
         @(posedge clk); #1;
      end
      drive(noise, noise, 8'($urandom));
      seen4 = 1'b0; seen8 = 1'b0; guard = 0;
      while (!(seen4 && seen8) && guard < 100) begin
         @(negedge clk);
         if (if4.done) seen4 = 1'b1;
         if (if8.done) seen8 = 1'b1;
         @(posedge clk); #1;
         if (seen4) if4.start = 1'b0;
         if (seen8) if8.start = 1'b0;
         guard++;
      end
      drive(1'b0, 1'b0, 8'h00);
      checks++;
      if (!(seen4 && seen8)) begin
         errors++;
         $display("FAIL done_timeout: seen4=%b seen8=%b, want both 1", seen4, seen8);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive(1'b0, 1'b0, 8'h00);
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++; if (sum_now[d] !== 1'b0) begin errors++; $display("FAIL reset_sum dut%0d: got %b want 0", d, sum_now[d]); end
         checks++; if (sv_now[d] !== 1'b0) begin errors++; $display("FAIL reset_sum_valid dut%0d: got %b want 0", d, sv_now[d]); end
         checks++; if (cnt_now[d] !== 9'd0) begin errors++; $display("FAIL reset_count dut%0d: got %0d want 0", d, cnt_now[d]); end
         checks++; if (busy_now[d] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d: got %b want 0", d, busy_now[d]); end
         checks++; if (done_now[d] !== 1'b0) begin errors++; $display("FAIL reset_done dut%0d: got %b want 0", d, done_now[d]); end
      end
      @(posedge clk); #1 rst = 1'b1;
   endtask

   task automatic test_stream(input string name, input int mode, input int gap_pct, input bit noise,
                              output int cnt4);
      int nstr, mism, expc, ndone, dep;
      do_run(mode, gap_pct, noise);
      repeat (6) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         dep = (d == 0) ? 2 : 3;
         expc = 0;
         for (int j = 0; j < L; j++) expc += int'(expv[d][j]);
         nstr = wp[d] - base_wp[d];
         checks++; if (nstr != L) begin errors++; $display("FAIL %s_strobes dut%0d: got %0d want %0d", name, d, nstr, L); end
         mism = 0;
         for (int j = 0; j < L; j++) if (got[d][(base_wp[d] + j) % 4096] !== expv[d][j]) mism++;
         checks++; if (mism != 0) begin errors++; $display("FAIL %s_sequence dut%0d: got %0d differing bits want 0", name, d, mism); end
         checks++; if (cnt_done[d] !== 9'(expc)) begin errors++; $display("FAIL %s_count dut%0d: got %0d want %0d", name, d, cnt_done[d], expc); end
         checks++; if (cnt_now[d] !== 9'(expc)) begin errors++; $display("FAIL %s_count_hold dut%0d: got %0d want %0d", name, d, cnt_now[d], expc); end
         ndone = done_n[d] - base_d[d];
         checks++; if (ndone != 1) begin errors++; $display("FAIL %s_done_pulses dut%0d: got %0d want 1", name, d, ndone); end
         checks++; if (busy_now[d] !== 1'b0) begin errors++; $display("FAIL %s_busy_idle dut%0d: got %b want 0", name, d, busy_now[d]); end
         if (gap_pct == 0) begin
            checks++;
            if (done_cyc[d] - first_cyc != L + dep) begin
               errors++; $display("FAIL %s_run_length dut%0d: got %0d want %0d", name, d, done_cyc[d] - first_cyc, L + dep);
            end
         end
         if (mode == 1) begin
            checks++; if (cnt_done[d] !== 9'(L)) begin errors++; $display("FAIL %s_full dut%0d: got %0d want %0d", name, d, cnt_done[d], L); end
         end
         if (mode == 0) begin
            checks++; if (cnt_done[d] !== 9'd0) begin errors++; $display("FAIL %s_empty dut%0d: got %0d want 0", name, d, cnt_done[d]); end
         end
         if (mode == 2 && d == 0) begin
            checks++;
            if (cnt_done[0] < 9'd48 || cnt_done[0] > 9'd80) begin
               errors++; $display("FAIL %s_window dut0: got %0d want 48..80", name, cnt_done[0]);
            end
         end
      end
      cnt4 = int'(cnt_done[0]);
   endtask

   task automatic test_onehot_repeat();
      int c1, c2;
      test_stream("onehot", 2, 0, 1'b0, c1);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      test_stream("onehot_rerun", 2, 0, 1'b0, c2);
      checks++;
      if (c1 != c2) begin errors++; $display("FAIL onehot_repeat: got %0d want %0d", c2, c1); end
   endtask

   task automatic test_gaps();
      int c;
      test_stream("onehot_gaps", 2, 30, 1'b0, c);
      test_stream("random_gaps", 3, 30, 1'b0, c);
   endtask

   task automatic test_random();
      int c;
      test_stream("random", 3, 0, 1'b0, c);
   endtask

   task automatic test_ignored_start();
      int c;
      test_stream("start_noise", 1, 0, 1'b1, c);
   endtask

   task automatic test_reset_midrun();
      int bd0, bd1, c;
      bd0 = done_n[0]; bd1 = done_n[1];
      @(posedge clk); #1 drive(1'b1, 1'b0, 8'hFF);
      @(posedge clk); #1 drive(1'b0, 1'b1, 8'hFF);
      repeat (60) @(posedge clk);
      @(negedge clk);
      checks++;
      if (cnt_now[0] == 9'd0) begin errors++; $display("FAIL midrun_count_progress dut0: got 0 want nonzero"); end
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++; if (busy_now[d] !== 1'b0) begin errors++; $display("FAIL midrun_busy dut%0d: got %b want 0", d, busy_now[d]); end
         checks++; if (cnt_now[d] !== 9'd0) begin errors++; $display("FAIL midrun_count dut%0d: got %0d want 0", d, cnt_now[d]); end
         checks++; if (sv_now[d] !== 1'b0) begin errors++; $display("FAIL midrun_sum_valid dut%0d: got %b want 0", d, sv_now[d]); end
      end
      @(posedge clk); #1 rst = 1'b1; drive(1'b0, 1'b0, 8'h00);
      repeat (20) @(negedge clk);
      checks++;
      if (done_n[0] != bd0 || done_n[1] != bd1) begin
         errors++; $display("FAIL midrun_no_done: got %0d/%0d extra pulses want 0/0", done_n[0] - bd0, done_n[1] - bd1);
      end
      test_stream("after_midrun_reset", 3, 0, 1'b0, c);
   endtask

   initial begin
      int c;
      test_reset();
      test_stream("all_ones", 1, 0, 1'b0, c);
      test_stream("all_zeros", 0, 0, 1'b0, c);
      test_onehot_repeat();
      test_gaps();
      test_random();
      test_ignored_start();
      test_reset_midrun();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
